branch_resolve_queue: RTL and testbench
=======================================

# branch_resolve_queue

Tracks every conditional branch predicted at fetch until execute resolves it, in program order. On resolution it compares the outcome against the stored prediction. It produces the one-cycle training pulse (`update_opcode`, `update_pc`, `actual_pred`, `mispred`) consumed by the 1-bit branch predictor, plus a redirect PC for fetch. It sits between the predictor/fetch stage and the execute-stage branch comparator.

## Interface
- `DATA_WIDTH`, 32, instruction width
- `ADDRESS_BITS`, 32, PC width
- `QUEUE_DEPTH`, 4, in-flight branch entries; power of two, ≥2
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `fetch_valid`  in  1  fetch slot holds a valid instruction
- `fetch_pc`  in  ADDRESS_BITS  PC of fetched instruction
- `fetch_instruction`  in  DATA_WIDTH  fetched instruction; opcode = bits [6:0]
- `fetch_prediction`  in  1  predictor direction (1 = taken)
- `fetch_predicted_pc`  in  ADDRESS_BITS  predictor taken target
- `fetch_ready`  out  1  queue can accept a branch this cycle
- `resolve_valid`  in  1  execute resolves the oldest in-flight branch
- `resolve_taken`  in  1  actual direction
- `resolve_target`  in  ADDRESS_BITS  actual taken target
- `flush`  in  1  external pipeline flush (exception/interrupt)
- `update_opcode`  out  7  1100011 during a training pulse, else 0
- `update_pc`  out  ADDRESS_BITS  PC of the resolved branch
- `actual_pred`  out  1  resolved direction
- `mispred`  out  1  prediction wrong (direction or target)
- `redirect_valid`  out  1  fetch must restart at `redirect_pc`
- `redirect_pc`  out  ADDRESS_BITS  correct next PC
- `queue_count`  out  $clog2(QUEUE_DEPTH)+1  occupied entries
- `resolve_error`  out  1  resolve arrived with the queue empty

## Operation
- Each entry holds {pc, prediction, predicted_pc}. The queue is a circular buffer with head and tail pointers that wrap modulo `QUEUE_DEPTH`, plus a count register.
- **Enqueue:** `fetch_valid` && opcode == 1100011 && `fetch_ready` && !kill. Non-branch instructions are ignored.
- `fetch_ready` = (count < QUEUE_DEPTH). It is combinational from count only and does not depend on a same-cycle pop.
- **Pop:** `resolve_valid` && count != 0. The head entry is compared:
  - mispred = (prediction != resolve_taken) || (resolve_taken && predicted_pc != resolve_target)
  - redirect_pc = resolve_taken ? resolve_target : pc + 4. The addition is modulo 2^ADDRESS_BITS and wraps.
- **Kill:** asserted when the popped entry mispredicts, or when `flush` is high. On kill, all entries are discarded (count ← 0, head = tail) and any same-cycle enqueue is dropped as wrong-path.
- Pop with empty queue: no state change, no training pulse, `resolve_error` pulses.
- `flush` with no pop: the queue clears, with no training pulse and no redirect.
- `flush` together with a valid pop: the training pulse for the popped branch is still emitted. `redirect_valid` is then driven by mispred only.
- Simultaneous push and pop without kill: count is unchanged.

## Timing
- All outputs are registered except `fetch_ready` and `queue_count`. `queue_count` is the count register itself.
- Resolve sampled at edge N: `update_*`, `actual_pred`, `mispred`, `redirect_*`, and `resolve_error` are valid for exactly cycle N→N+1, then return to 0.
  - `update_opcode` = 0 when no pulse is active.
  - `redirect_valid` = mispred of the pulse.
- Enqueue sampled at edge N is visible in `queue_count` after N.
- Kill takes effect at the same edge as the pop; fetch sees `redirect_valid` one cycle later.
- Reset forces all outputs to 0 and count to 0. `fetch_ready` = 1 after reset. Reset mid-operation discards all in-flight entries with no pulse.

## Test plan
- **Correct prediction:** enqueue BEQ pc=0x100, pred=1, ppc=0x140; resolve taken, target=0x140 → next cycle update_opcode=1100011, update_pc=0x100, actual_pred=1, mispred=0, redirect_valid=0; count returns to 0.
- **Direction mispredict with flush of younger entries:** enqueue 3 branches (pred=0 each); resolve first taken, target=0x200 → mispred=1, redirect_valid=1, redirect_pc=0x200; queue_count=0; a push in the resolve cycle is dropped.
- **Not-taken mispredict and wrap:** pred=1, resolve not-taken, pc=0xFFFFFFFC → redirect_pc=0x00000000.
- **Full and non-branch handling:** fill 4 entries → fetch_ready=0; a 5th branch is not stored. A non-branch (opcode 0110011) with fetch_valid does not change count. After one correct resolve, fetch_ready=1. Run 10 push/pop cycles to exercise pointer wrap, with in-order update_pc.
- **Empty resolve:** resolve_valid with count=0 → resolve_error=1 for one cycle, update_opcode=0.
- **Flush and reset:** flush with 2 entries → count=0 and no pulse. Reset mid-operation → all outputs 0 next cycle, fetch_ready=1.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of predicted branches, resolved against execute outcomes to train the predictor and redirect fetch
module branch_resolve_queue #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int QUEUE_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_valid,
    input  logic [ADDRESS_BITS-1:0]      fetch_pc,
    input  logic [DATA_WIDTH-1:0]        fetch_instruction,
    input  logic                         fetch_prediction,
    input  logic [ADDRESS_BITS-1:0]      fetch_predicted_pc,
    output logic                         fetch_ready,
    input  logic                         resolve_valid,
    input  logic                         resolve_taken,
    input  logic [ADDRESS_BITS-1:0]      resolve_target,
    input  logic                         flush,
    output logic [6:0]                   update_opcode,
    output logic [ADDRESS_BITS-1:0]      update_pc,
    output logic                         actual_pred,
    output logic                         mispred,
    output logic                         redirect_valid,
    output logic [ADDRESS_BITS-1:0]      redirect_pc,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic                         resolve_error
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [6:0] BRANCH = 7'b1100011;

    logic [ADDRESS_BITS-1:0] pc_q  [QUEUE_DEPTH];
    logic [ADDRESS_BITS-1:0] ppc_q [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0]  pred_q;
    logic [PW-1:0]           head, tail;
    logic [CW-1:0]           count;
    logic                    pop, push, miss, kill;
    logic [ADDRESS_BITS-1:0] next_pc;
    logic                    unused_instr;

    assign unused_instr = ^fetch_instruction[DATA_WIDTH-1:7];
    assign queue_count  = count;

    always_comb begin
        fetch_ready = count < CW'(QUEUE_DEPTH);
        pop         = resolve_valid && count != '0;
        miss        = (pred_q[head] != resolve_taken) || (resolve_taken && ppc_q[head] != resolve_target);
        kill        = (pop && miss) || flush;
        push        = fetch_valid && fetch_instruction[6:0] == BRANCH && fetch_ready && !kill;
        next_pc     = resolve_taken ? resolve_target : pc_q[head] + ADDRESS_BITS'(4);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail]   <= fetch_pc;
            ppc_q[tail]  <= fetch_predicted_pc;
            pred_q[tail] <= fetch_prediction;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            update_opcode  <= '0;
            update_pc      <= '0;
            actual_pred    <= 1'b0;
            mispred        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            resolve_error  <= 1'b0;
        end else begin
            head           <= kill ? '0 : head + PW'(pop);
            tail           <= kill ? '0 : tail + PW'(push);
            count          <= kill ? '0 : count + CW'(push) - CW'(pop);
            update_opcode  <= pop ? BRANCH : '0;
            update_pc      <= pop ? pc_q[head] : '0;
            actual_pred    <= pop && resolve_taken;
            mispred        <= pop && miss;
            redirect_valid <= pop && miss;
            redirect_pc    <= pop ? next_pc : '0;
            resolve_error  <= resolve_valid && count == '0;
        end
    end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed and random checks of branch_resolve_queue against a queue-based model
module tb_branch_resolve_queue;
    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] ppc;
    } ent_t;

    localparam logic [31:0] BR = 32'h0000_0063;
    localparam logic [31:0] NB = 32'h0000_0033;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic [31:0] fetch_instruction = '0;
    logic        fetch_prediction = 1'b0;
    logic [31:0] fetch_predicted_pc = '0;
    logic        fetch_ready;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic [31:0] resolve_target = '0;
    logic        flush = 1'b0;
    logic [6:0]  update_opcode;
    logic [31:0] update_pc;
    logic        actual_pred;
    logic        mispred;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  queue_count;
    logic        resolve_error;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];

    branch_resolve_queue dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instruction(fetch_instruction),
        .fetch_prediction(fetch_prediction), .fetch_predicted_pc(fetch_predicted_pc), .fetch_ready(fetch_ready),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .flush(flush), .update_opcode(update_opcode), .update_pc(update_pc), .actual_pred(actual_pred),
        .mispred(mispred), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .queue_count(queue_count), .resolve_error(resolve_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic fv, input logic [31:0] fpc, input logic [31:0] finstr, input logic fpred,
                         input logic [31:0] fppc, input logic rv, input logic rt, input logic [31:0] rtgt,
                         input logic fl);
        ent_t h;
        logic pop, mis, kill, push;
        logic [31:0] rpc;
        @(negedge clk);
        fetch_valid = fv; fetch_pc = fpc; fetch_instruction = finstr; fetch_prediction = fpred;
        fetch_predicted_pc = fppc; resolve_valid = rv; resolve_taken = rt; resolve_target = rtgt; flush = fl;
        #1;
        chk("fetch_ready", {63'd0, fetch_ready}, {63'd0, q.size() < 4});
        chk("count_pre", {61'd0, queue_count}, 64'(q.size()));
        pop = rv && q.size() != 0;
        h = '0; mis = 1'b0; rpc = '0;
        if (pop) begin
            h = q[0];
            mis = (h.pred != rt) || (rt && h.ppc != rtgt);
            rpc = rt ? rtgt : h.pc + 32'd4;
        end
        kill = (pop && mis) || fl;
        push = fv && finstr[6:0] == 7'h63 && q.size() < 4 && !kill;
        @(posedge clk);
        if (kill) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{fpc, fpred, fppc});
        end
        #1;
        chk("update_opcode", {57'd0, update_opcode}, pop ? 64'h63 : 64'h0);
        chk("update_pc", {32'd0, update_pc}, {32'd0, h.pc});
        chk("actual_pred", {63'd0, actual_pred}, {63'd0, pop && rt});
        chk("mispred", {63'd0, mispred}, {63'd0, mis});
        chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, mis});
        chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, rpc});
        chk("resolve_error", {63'd0, resolve_error}, {63'd0, rv && !pop});
        chk("count_post", {61'd0, queue_count}, 64'(q.size()));
    endtask

    task automatic push_br(input logic [31:0] pc, input logic pred, input logic [31:0] ppc);
        cycle(1'b1, pc, BR, pred, ppc, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic resolve(input logic rt, input logic [31:0] tgt);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, rt, tgt, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; fetch_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
        @(posedge clk);
        q.delete();
        #1;
        chk("rst_opcode", {57'd0, update_opcode}, 64'h0);
        chk("rst_update_pc", {32'd0, update_pc}, 64'h0);
        chk("rst_actual_pred", {63'd0, actual_pred}, 64'h0);
        chk("rst_mispred", {63'd0, mispred}, 64'h0);
        chk("rst_redirect_valid", {63'd0, redirect_valid}, 64'h0);
        chk("rst_redirect_pc", {32'd0, redirect_pc}, 64'h0);
        chk("rst_resolve_error", {63'd0, resolve_error}, 64'h0);
        chk("rst_count", {61'd0, queue_count}, 64'h0);
        chk("rst_fetch_ready", {63'd0, fetch_ready}, 64'h1);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] tmp;
        logic        fv, pr, rv, rt, fl;
        logic [31:0] pc, ppc, tgt, ins;
        do_reset();
        do_reset();

        push_br(32'h100, 1'b1, 32'h140);
        resolve(1'b1, 32'h140);
        chk("tp1_update_pc", {32'd0, update_pc}, 64'h100);
        chk("tp1_mispred", {63'd0, mispred}, 64'h0);
        chk("tp1_count", {61'd0, queue_count}, 64'h0);

        push_br(32'h300, 1'b0, 32'h0);
        push_br(32'h304, 1'b0, 32'h0);
        push_br(32'h308, 1'b0, 32'h0);
        cycle(1'b1, 32'h30c, BR, 1'b0, '0, 1'b1, 1'b1, 32'h200, 1'b0);
        chk("tp2_redirect_pc", {32'd0, redirect_pc}, 64'h200);
        chk("tp2_redirect_valid", {63'd0, redirect_valid}, 64'h1);
        chk("tp2_count", {61'd0, queue_count}, 64'h0);

        push_br(32'hFFFF_FFFC, 1'b1, 32'h10);
        resolve(1'b0, 32'h0);
        chk("tp3_wrap_pc", {32'd0, redirect_pc}, 64'h0);
        chk("tp3_mispred", {63'd0, mispred}, 64'h1);

        for (int i = 0; i < 5; i++) push_br(32'h400 + 32'(i * 4), 1'b1, 32'h500 + 32'(i * 4));
        chk("tp4_full_count", {61'd0, queue_count}, 64'h4);
        chk("tp4_full_ready", {63'd0, fetch_ready}, 64'h0);
        resolve(1'b1, 32'h500);
        chk("tp4_ready_after", {63'd0, fetch_ready}, 64'h1);
        cycle(1'b1, 32'h900, NB, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("tp4_nonbranch", {61'd0, queue_count}, 64'h3);
        for (int i = 0; i < 10; i++) begin
            tgt = q[0].ppc;
            cycle(1'b1, 32'h600 + 32'(i * 4), BR, 1'b1, 32'h700 + 32'(i * 4), 1'b1, 1'b1, tgt, 1'b0);
        end
        chk("tp4_last_pc", {32'd0, update_pc}, 64'h618);

        cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        resolve(1'b1, 32'h40);
        chk("tp5_resolve_error", {63'd0, resolve_error}, 64'h1);
        chk("tp5_opcode", {57'd0, update_opcode}, 64'h0);

        push_br(32'h800, 1'b0, '0);
        push_br(32'h804, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk("tp6_flush_count", {61'd0, queue_count}, 64'h0);
        push_br(32'h808, 1'b1, 32'h80);
        push_br(32'h80c, 1'b1, 32'h90);
        do_reset();

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) do_reset();
            else begin
                tmp = $urandom();
                fv  = $urandom_range(0, 99) < 70;
                ins = {tmp[31:7], ($urandom_range(0, 9) < 8) ? 7'h63 : 7'h33};
                pc  = $urandom() & 32'hFFFF_FFFC;
                pr  = 1'($urandom_range(0, 1));
                ppc = $urandom() & 32'hFFFF_FFFC;
                rv  = $urandom_range(0, 99) < 45;
                rt  = 1'($urandom_range(0, 1));
                tgt = $urandom() & 32'hFFFF_FFFC;
                if (q.size() != 0) begin
                    if ($urandom_range(0, 99) < 75) begin
                        rt = q[0].pred;
                        tgt = q[0].ppc;
                    end else if ($urandom_range(0, 1) == 1) tgt = q[0].ppc;
                end
                fl = $urandom_range(0, 99) < 3;
                cycle(fv, pc, ins, pr, ppc, rv, rt, tgt, fl);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
